// File: rtl/riscv_opcodes_pkg.sv
// Opcode constants, execution classes and privilege encodings shared by the
// instruction classifier and its bench.
package riscv_opcodes_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_AMO       = 7'b0101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    localparam logic [31:0] INSTR_ECALL      = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK     = 32'h0010_0073;
    localparam logic [31:0] INSTR_URET       = 32'h0020_0073;
    localparam logic [31:0] INSTR_SRET       = 32'h1020_0073;
    localparam logic [31:0] INSTR_MRET       = 32'h3020_0073;
    localparam logic [31:0] INSTR_WFI        = 32'h1050_0073;
    localparam logic [31:0] SFENCE_VMA_MASK  = 32'hFE00_7FFF;
    localparam logic [31:0] SFENCE_VMA_MATCH = 32'h1200_0073;

    typedef enum logic [3:0] {
        CLS_ALU       = 4'd0,
        CLS_ALU_W     = 4'd1,
        CLS_LOAD      = 4'd2,
        CLS_STORE     = 4'd3,
        CLS_BRANCH    = 4'd4,
        CLS_JUMP      = 4'd5,
        CLS_LUI_AUIPC = 4'd6,
        CLS_MUL       = 4'd7,
        CLS_DIV       = 4'd8,
        CLS_AMO       = 4'd9,
        CLS_CSR       = 4'd10,
        CLS_SYSTEM    = 4'd11,
        CLS_FENCE     = 4'd12,
        CLS_ILLEGAL   = 4'd15
    } class_t;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_M = 2'b11;

endpackage

// File: rtl/riscv_skidbuf2.sv
// Two-entry valid/ready FIFO with synchronous flush; input ready comes
// straight from a register so the upstream path sees no combinational loop.
module riscv_skidbuf2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push        = in_valid_i && ready_q && !flush_i;
    assign pop         = (cnt_q != 2'd0) && out_ready_i;
    assign in_ready_o  = ready_q;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Ready for next cycle is decided from the post-update occupancy, so a
    // pop from full reopens the input one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
            if (flush_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_data_i;
                    wr_ptr_q        <= !wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= !rd_ptr_q;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_instr_classifier.sv
// Registered instruction classifier: tags each accepted instruction with an
// execution class and illegal flag, buffers two results, counts illegal hand-offs.
module riscv_instr_classifier
    import riscv_opcodes_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          HAS_RVM = 1'b0,
    parameter bit          HAS_RVA = 1'b0,
    parameter bit          HAS_S   = 1'b0,
    parameter bit          HAS_U   = 1'b0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic [1:0]       priv_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [31:0]      dec_instr_o,
    output logic [XLEN-1:0]  dec_pc_o,
    output logic [3:0]       dec_class_o,
    output logic             dec_illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam bit          IS_RV64 = (XLEN == 64);
    localparam int unsigned PW      = XLEN + 37;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    class_t           raw_cls;
    logic             need_rv64;
    logic             need_m;
    logic             need_a;
    logic             priv_ok;
    logic             illegal;
    logic [3:0]       cls_code;
    logic [PW-1:0]    in_data;
    logic [PW-1:0]    out_data;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Pattern match first, then apply ISA-subset and privilege restrictions.
    always_comb begin
        raw_cls   = CLS_ILLEGAL;
        need_rv64 = 1'b0;
        need_m    = 1'b0;
        need_a    = 1'b0;
        priv_ok   = 1'b1;
        case (opcode)
            OPC_LUI, OPC_AUIPC: raw_cls = CLS_LUI_AUIPC;
            OPC_JAL:            raw_cls = CLS_JUMP;
            OPC_JALR:           if (funct3 == 3'b000) raw_cls = CLS_JUMP;
            OPC_BRANCH:         if (funct3 != 3'b010 && funct3 != 3'b011) raw_cls = CLS_BRANCH;
            OPC_LOAD: begin
                if (funct3 != 3'b111) raw_cls = CLS_LOAD;
                need_rv64 = (funct3 == 3'b011) || (funct3 == 3'b110);
            end
            OPC_STORE: begin
                if (!funct3[2]) raw_cls = CLS_STORE;
                need_rv64 = (funct3 == 3'b011);
            end
            OPC_OP_IMM: begin
                need_rv64 = (funct3[1:0] == 2'b01) && instr_i[25];
                case (funct3)
                    3'b001:  if (instr_i[31:26] == 6'b000000) raw_cls = CLS_ALU;
                    3'b101:  if (instr_i[31:26] == 6'b000000 || instr_i[31:26] == 6'b010000)
                                 raw_cls = CLS_ALU;
                    default: raw_cls = CLS_ALU;
                endcase
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    raw_cls = CLS_ALU;
                end else if (funct7 == 7'b0000001) begin
                    raw_cls = funct3[2] ? CLS_DIV : CLS_MUL;
                    need_m  = 1'b1;
                end
            end
            OPC_OP_IMM_32: begin
                need_rv64 = 1'b1;
                case (funct3)
                    3'b000:  raw_cls = CLS_ALU_W;
                    3'b001:  if (funct7 == 7'b0000000) raw_cls = CLS_ALU_W;
                    3'b101:  if (funct7 == 7'b0000000 || funct7 == 7'b0100000) raw_cls = CLS_ALU_W;
                    default: raw_cls = CLS_ILLEGAL;
                endcase
            end
            OPC_OP_32: begin
                need_rv64 = 1'b1;
                if (funct7 == 7'b0000000 &&
                    (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) begin
                    raw_cls = CLS_ALU_W;
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    raw_cls = CLS_ALU_W;
                end else if (funct7 == 7'b0000001) begin
                    need_m = 1'b1;
                    if (funct3 == 3'b000)  raw_cls = CLS_MUL;
                    else if (funct3[2])    raw_cls = CLS_DIV;
                end
            end
            OPC_AMO: begin
                need_a    = 1'b1;
                need_rv64 = (funct3 == 3'b011);
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    case (instr_i[31:27])
                        AMO_LR:  if (instr_i[24:20] == 5'd0) raw_cls = CLS_AMO;
                        AMO_SC, AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND, AMO_OR,
                        AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: raw_cls = CLS_AMO;
                        default: raw_cls = CLS_ILLEGAL;
                    endcase
                end
            end
            OPC_MISC_MEM: if (funct3 == 3'b000 || funct3 == 3'b001) raw_cls = CLS_FENCE;
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    case (instr_i)
                        INSTR_ECALL, INSTR_EBREAK: raw_cls = CLS_SYSTEM;
                        INSTR_URET: begin
                            raw_cls = CLS_SYSTEM;
                            priv_ok = HAS_U;
                        end
                        INSTR_SRET: begin
                            raw_cls = CLS_SYSTEM;
                            priv_ok = HAS_S && (priv_i != PRV_U);
                        end
                        INSTR_MRET: begin
                            raw_cls = CLS_SYSTEM;
                            priv_ok = (priv_i == PRV_M);
                        end
                        INSTR_WFI: begin
                            raw_cls = CLS_SYSTEM;
                            priv_ok = (priv_i != PRV_U);
                        end
                        default: begin
                            if ((instr_i & SFENCE_VMA_MASK) == SFENCE_VMA_MATCH) begin
                                raw_cls = CLS_SYSTEM;
                                priv_ok = HAS_S && (priv_i != PRV_U);
                            end
                        end
                    endcase
                end else if (funct3 != 3'b100) begin
                    raw_cls = CLS_CSR;
                end
            end
            default: raw_cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal  = (instr_i[1:0] != 2'b11) || (raw_cls == CLS_ILLEGAL) ||
                      (need_rv64 && !IS_RV64) || (need_m && !HAS_RVM) ||
                      (need_a && !HAS_RVA) || !priv_ok;
    assign cls_code = illegal ? CLS_ILLEGAL : raw_cls;
    assign in_data  = {illegal, cls_code, pc_i, instr_i};

    riscv_skidbuf2 #(
        .WIDTH (PW)
    ) u_skidbuf (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_i),
        .in_valid_i  (instr_valid_i),
        .in_ready_o  (instr_ready_o),
        .in_data_i   (in_data),
        .out_valid_o (dec_valid_o),
        .out_ready_i (dec_ready_i),
        .out_data_o  (out_data)
    );

    assign dec_instr_o   = out_data[31:0];
    assign dec_pc_o      = out_data[XLEN+31:32];
    assign dec_class_o   = out_data[XLEN+35:XLEN+32];
    assign dec_illegal_o = out_data[XLEN+36];

    // Only rstn clears the count; a transfer coinciding with flush still counts.
    always_comb begin
        cnt_d = cnt_q;
        if (dec_valid_o && dec_ready_i && dec_illegal_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_instr_classifier.sv
// Drives an RV32 base-only classifier and an RV64 full-featured classifier
// (2-bit counter) in lockstep and checks both against a table-driven model.
module tb_riscv_instr_classifier;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  cls;
        bit          rv64;
        bit          m;
        bit          a;
        int          rule;
    } pat_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [3:0]  cls;
        logic        ill;
    } exp_t;

    localparam logic [31:0] M_OP = 32'h0000_007F;
    localparam logic [31:0] M_F3 = 32'h0000_707F;
    localparam logic [31:0] M_F7 = 32'hFE00_707F;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic [1:0]  priv;
    logic        instrValid;
    logic [31:0] instr;
    logic [63:0] pcIn;
    logic        decReady;

    logic        instrReady32, instrReady64;
    logic        decValid32, decValid64;
    logic [31:0] decInstr32, decInstr64;
    logic [31:0] decPc32;
    logic [63:0] decPc64;
    logic [3:0]  decClass32, decClass64;
    logic        decIllegal32, decIllegal64;
    logic [15:0] illegalCnt32;
    logic [1:0]  illegalCnt64;

    pat_t pats[$];
    exp_t q32[$];
    exp_t q64[$];
    int   cnt32;
    int   cnt64;
    int   passCount;
    int   failCount;
    int   checkCount;
    bit   lastConsumed;

    riscv_instr_classifier #(
        .XLEN(32), .HAS_RVM(1'b0), .HAS_RVA(1'b0), .HAS_S(1'b0), .HAS_U(1'b0), .CNT_W(16)
    ) dut32 (
        .clk(clk), .rstn(rstn), .flush_i(flush), .priv_i(priv),
        .instr_valid_i(instrValid), .instr_ready_o(instrReady32),
        .instr_i(instr), .pc_i(pcIn[31:0]),
        .dec_valid_o(decValid32), .dec_ready_i(decReady),
        .dec_instr_o(decInstr32), .dec_pc_o(decPc32),
        .dec_class_o(decClass32), .dec_illegal_o(decIllegal32),
        .illegal_cnt_o(illegalCnt32)
    );

    riscv_instr_classifier #(
        .XLEN(64), .HAS_RVM(1'b1), .HAS_RVA(1'b1), .HAS_S(1'b1), .HAS_U(1'b1), .CNT_W(2)
    ) dut64 (
        .clk(clk), .rstn(rstn), .flush_i(flush), .priv_i(priv),
        .instr_valid_i(instrValid), .instr_ready_o(instrReady64),
        .instr_i(instr), .pc_i(pcIn),
        .dec_valid_o(decValid64), .dec_ready_i(decReady),
        .dec_instr_o(decInstr64), .dec_pc_o(decPc64),
        .dec_class_o(decClass64), .dec_illegal_o(decIllegal64),
        .illegal_cnt_o(illegalCnt64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc(input int op, input int f3, input int f7);
        return 32'((f7 << 25) | (f3 << 12) | op);
    endfunction

    task automatic addPat(input logic [31:0] mask, input logic [31:0] match, input int cls,
                          input bit rv64, input bit m, input bit a, input int rule);
        pat_t p;
        p.mask  = mask;
        p.match = match;
        p.cls   = 4'(cls);
        p.rv64  = rv64;
        p.m     = m;
        p.a     = a;
        p.rule  = rule;
        pats.push_back(p);
    endtask

    // Instruction table; rule: 1=URET 2=SRET/SFENCE 3=MRET 4=WFI 5=HRET
    task automatic buildPatterns();
        int brF3[6]  = '{0, 1, 4, 5, 6, 7};
        int ldF3[5]  = '{0, 1, 2, 4, 5};
        int aluF3[6] = '{0, 2, 3, 4, 6, 7};
        int amoF5[10] = '{0, 1, 3, 4, 8, 12, 16, 20, 24, 28};
        int csrF3[6] = '{1, 2, 3, 5, 6, 7};
        addPat(M_OP, enc('h37, 0, 0), 6, 0, 0, 0, 0);
        addPat(M_OP, enc('h17, 0, 0), 6, 0, 0, 0, 0);
        addPat(M_OP, enc('h6F, 0, 0), 5, 0, 0, 0, 0);
        addPat(M_F3, enc('h67, 0, 0), 5, 0, 0, 0, 0);
        foreach (brF3[k]) addPat(M_F3, enc('h63, brF3[k], 0), 4, 0, 0, 0, 0);
        foreach (ldF3[k]) addPat(M_F3, enc('h03, ldF3[k], 0), 2, 0, 0, 0, 0);
        addPat(M_F3, enc('h03, 3, 0), 2, 1, 0, 0, 0);
        addPat(M_F3, enc('h03, 6, 0), 2, 1, 0, 0, 0);
        for (int f = 0; f < 3; f++) addPat(M_F3, enc('h23, f, 0), 3, 0, 0, 0, 0);
        addPat(M_F3, enc('h23, 3, 0), 3, 1, 0, 0, 0);
        foreach (aluF3[k]) addPat(M_F3, enc('h13, aluF3[k], 0), 0, 0, 0, 0, 0);
        addPat(M_F7, enc('h13, 1, 'h00), 0, 0, 0, 0, 0);
        addPat(M_F7, enc('h13, 1, 'h01), 0, 1, 0, 0, 0);
        addPat(M_F7, enc('h13, 5, 'h00), 0, 0, 0, 0, 0);
        addPat(M_F7, enc('h13, 5, 'h01), 0, 1, 0, 0, 0);
        addPat(M_F7, enc('h13, 5, 'h20), 0, 0, 0, 0, 0);
        addPat(M_F7, enc('h13, 5, 'h21), 0, 1, 0, 0, 0);
        for (int f = 0; f < 8; f++) begin
            addPat(M_F7, enc('h33, f, 'h00), 0, 0, 0, 0, 0);
            addPat(M_F7, enc('h33, f, 'h01), (f < 4) ? 7 : 8, 0, 1, 0, 0);
        end
        addPat(M_F7, enc('h33, 0, 'h20), 0, 0, 0, 0, 0);
        addPat(M_F7, enc('h33, 5, 'h20), 0, 0, 0, 0, 0);
        addPat(M_F3, enc('h1B, 0, 0), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h1B, 1, 'h00), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h1B, 5, 'h00), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h1B, 5, 'h20), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h3B, 0, 'h00), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h3B, 1, 'h00), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h3B, 5, 'h00), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h3B, 0, 'h20), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h3B, 5, 'h20), 1, 1, 0, 0, 0);
        addPat(M_F7, enc('h3B, 0, 'h01), 7, 1, 1, 0, 0);
        for (int f = 4; f < 8; f++) addPat(M_F7, enc('h3B, f, 'h01), 8, 1, 1, 0, 0);
        for (int w = 2; w < 4; w++) begin
            foreach (amoF5[k]) addPat(32'hF800_707F, 32'((amoF5[k] << 27) | (w << 12) | 'h2F), 9, w == 3, 0, 1, 0);
            addPat(32'hF9F0_707F, 32'((2 << 27) | (w << 12) | 'h2F), 9, w == 3, 0, 1, 0);
        end
        addPat(M_F3, enc('h0F, 0, 0), 12, 0, 0, 0, 0);
        addPat(M_F3, enc('h0F, 1, 0), 12, 0, 0, 0, 0);
        foreach (csrF3[k]) addPat(M_F3, enc('h73, csrF3[k], 0), 10, 0, 0, 0, 0);
        addPat(32'hFFFF_FFFF, 32'h0000_0073, 11, 0, 0, 0, 0);
        addPat(32'hFFFF_FFFF, 32'h0010_0073, 11, 0, 0, 0, 0);
        addPat(32'hFFFF_FFFF, 32'h0020_0073, 11, 0, 0, 0, 1);
        addPat(32'hFFFF_FFFF, 32'h1020_0073, 11, 0, 0, 0, 2);
        addPat(32'hFFFF_FFFF, 32'h3020_0073, 11, 0, 0, 0, 3);
        addPat(32'hFFFF_FFFF, 32'h1050_0073, 11, 0, 0, 0, 4);
        addPat(32'hFFFF_FFFF, 32'h2020_0073, 11, 0, 0, 0, 5);
        addPat(32'hFE00_7FFF, 32'h1200_0073, 11, 0, 0, 0, 2);
    endtask

    function automatic void classify(input logic [31:0] ins, input logic [1:0] pr,
                                     input bit x64, input bit hasM, input bit hasA,
                                     input bit hasS, input bit hasU,
                                     output logic [3:0] cls, output logic ill);
        bit   found = 1'b0;
        bit   ok;
        pat_t p;
        cls = 4'd15;
        ill = 1'b1;
        foreach (pats[k]) begin
            if (!found && ((ins & pats[k].mask) == pats[k].match)) begin
                found = 1'b1;
                p     = pats[k];
            end
        end
        if (found && ins[1:0] == 2'b11) begin
            ok = !(p.rv64 && !x64) && !(p.m && !hasM) && !(p.a && !hasA);
            case (p.rule)
                1:       ok = ok && hasU;
                2:       ok = ok && hasS && (pr != 2'b00);
                3:       ok = ok && (pr == 2'b11);
                4:       ok = ok && (pr != 2'b00);
                5:       ok = 1'b0;
                default: ok = ok;
            endcase
            if (ok) begin
                cls = p.cls;
                ill = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] randInstr();
        pat_t p;
        if ($urandom_range(0, 9) < 3) return $urandom;
        p = pats[$urandom_range(0, pats.size() - 1)];
        return (p.match & p.mask) | ($urandom & ~p.mask);
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checkCount++;
        assert (obs === expv) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Handshake state and counters after the latest clock edge.
    task automatic checkOutput();
        checkVal("dut32 ready", 64'(instrReady32), 64'(q32.size() < 2));
        checkVal("dut64 ready", 64'(instrReady64), 64'(q64.size() < 2));
        checkVal("dut32 valid", 64'(decValid32), 64'(q32.size() > 0));
        checkVal("dut64 valid", 64'(decValid64), 64'(q64.size() > 0));
        checkVal("dut32 count", 64'(illegalCnt32), 64'(cnt32));
        checkVal("dut64 count", 64'(illegalCnt64), 64'(cnt64));
    endtask

    // One clock cycle: drive inputs, check any outgoing entry, advance the model.
    task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                                 input logic [1:0] pr, input bit rdy, input bit fl);
        exp_t e32;
        exp_t e64;
        bit   acc;
        bit   pop;
        instrValid = v;
        instr      = ins;
        pcIn       = pc;
        priv       = pr;
        decReady   = rdy;
        flush      = fl;
        #1;
        acc = v && (q32.size() < 2);
        pop = rdy && (q32.size() > 0);
        lastConsumed = acc || (v && fl);
        if (pop) begin
            checkVal("dut32 out instr", 64'(decInstr32), 64'(q32[0].instr));
            checkVal("dut32 out pc", 64'(decPc32), q32[0].pc);
            checkVal("dut32 out class", 64'(decClass32), 64'(q32[0].cls));
            checkVal("dut32 out illegal", 64'(decIllegal32), 64'(q32[0].ill));
            checkVal("dut64 out instr", 64'(decInstr64), 64'(q64[0].instr));
            checkVal("dut64 out pc", decPc64, q64[0].pc);
            checkVal("dut64 out class", 64'(decClass64), 64'(q64[0].cls));
            checkVal("dut64 out illegal", 64'(decIllegal64), 64'(q64[0].ill));
        end
        if (acc) begin
            e32.instr = ins;
            e32.pc    = {32'd0, pc[31:0]};
            classify(ins, pr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e32.cls, e32.ill);
            e64.instr = ins;
            e64.pc    = pc;
            classify(ins, pr, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, e64.cls, e64.ill);
        end
        @(posedge clk);
        if (pop && q32[0].ill) cnt32 = (cnt32 == 65535) ? 65535 : cnt32 + 1;
        if (pop && q64[0].ill) cnt64 = (cnt64 == 3) ? 3 : cnt64 + 1;
        if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (pop) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (acc) begin
                q32.push_back(e32);
                q64.push_back(e64);
            end
        end
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        bit          holdValid;
        bit          v;
        logic [31:0] ins;
        logic [63:0] pc;
        logic [1:0]  pr;
        logic [1:0]  privs[3];
        privs      = '{2'b00, 2'b01, 2'b11};
        passCount  = 0;
        failCount  = 0;
        checkCount = 0;
        cnt32      = 0;
        cnt64      = 0;
        buildPatterns();

        rstn       = 1'b0;
        flush      = 1'b0;
        priv       = 2'b11;
        instrValid = 1'b0;
        instr      = '0;
        pcIn       = '0;
        decReady   = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput();
        checkVal("rst dut32 instr", 64'(decInstr32), 64'd0);
        checkVal("rst dut32 pc", 64'(decPc32), 64'd0);
        checkVal("rst dut32 class", 64'(decClass32), 64'd0);
        checkVal("rst dut32 illegal", 64'(decIllegal32), 64'd0);
        checkVal("rst dut64 instr", 64'(decInstr64), 64'd0);
        checkVal("rst dut64 pc", decPc64, 64'd0);
        checkVal("rst dut64 class", 64'(decClass64), 64'd0);
        checkVal("rst dut64 illegal", 64'(decIllegal64), 64'd0);
        @(negedge clk);

        $display("[TB] ADD, MUL, LD, MRET under two privileges");
        applyStimulus(1, 32'h003100B3, 64'h1000, 2'b11, 1, 0);
        applyStimulus(1, 32'h02208033, 64'h1004, 2'b11, 1, 0);
        applyStimulus(1, 32'h0000B003, 64'h1008, 2'b11, 1, 0);
        applyStimulus(1, 32'h30200073, 64'h100C, 2'b00, 1, 0);
        applyStimulus(1, 32'h30200073, 64'h1010, 2'b11, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b11, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b11, 1, 0);

        $display("[TB] privilege change after acceptance");
        applyStimulus(1, 32'h30200073, 64'h2000, 2'b11, 0, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b00, 0, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b00, 1, 0);

        $display("[TB] back-pressure with three back-to-back inputs");
        applyStimulus(1, 32'h00000013, 64'h3000, 2'b11, 0, 0);
        applyStimulus(1, 32'h00100093, 64'h3004, 2'b11, 0, 0);
        applyStimulus(1, 32'h00200113, 64'h3008, 2'b11, 0, 0);
        applyStimulus(1, 32'h00200113, 64'h3008, 2'b11, 1, 0);
        applyStimulus(1, 32'h00200113, 64'h3008, 2'b11, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b11, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b11, 1, 0);

        $display("[TB] flush while full and flush with a coincident transfer");
        applyStimulus(1, 32'h20200073, 64'h4000, 2'b11, 0, 0);
        applyStimulus(1, 32'h20200073, 64'h4004, 2'b11, 0, 0);
        applyStimulus(1, 32'h00000013, 64'h4008, 2'b11, 0, 1);
        applyStimulus(1, 32'h20200073, 64'h400C, 2'b11, 0, 0);
        applyStimulus(1, 32'h00000013, 64'h4010, 2'b11, 1, 1);

        $display("[TB] counter saturation");
        repeat (5) applyStimulus(1, 32'h20200073, 64'h5000, 2'b11, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b11, 1, 0);

        $display("[TB] randomized traffic");
        holdValid = 1'b0;
        v   = 1'b0;
        ins = '0;
        pc  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!holdValid) begin
                v   = ($urandom_range(0, 3) != 0);
                ins = randInstr();
                pc  = {$urandom, $urandom};
            end
            pr = privs[$urandom_range(0, 2)];
            applyStimulus(v, ins, pc, pr, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            holdValid = v && !lastConsumed;
        end

        $display("[TB] asynchronous reset with entries pending");
        applyStimulus(1, 32'h20200073, 64'h6000, 2'b11, 0, 0);
        applyStimulus(1, 32'h003100B3, 64'h6004, 2'b11, 0, 0);
        instrValid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        q32.delete();
        q64.delete();
        cnt32 = 0;
        cnt64 = 0;
        checkOutput();
        checkVal("arst dut32 instr", 64'(decInstr32), 64'd0);
        checkVal("arst dut64 instr", 64'(decInstr64), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1, 32'h003100B3, 64'h7000, 2'b11, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 2'b11, 1, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
